// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side and arbiter-side view of the shared 8:1 single-bit mux.
// Requesters drive req/d_in; the arbiter returns grant, select and the registered mux bit.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] d_in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       y_out;
  logic       y_valid;
  logic       timeout;

  modport master (
    output req, d_in,
    input  gnt, sel, busy, y_out, y_valid, timeout
  );

  modport slave (
    input  req, d_in,
    output gnt, sel, busy, y_out, y_valid, timeout
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of the 8:1 data mux: req -> gnt/sel one edge later -> y_out one edge after that.
// No backpressure; each hold is capped at MAX_HOLD cycles and followed by one dead cycle.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  mux8_rr_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_ptr;
  logic [2:0]    r_sel;
  logic [7:0]    r_gnt;
  logic [CW-1:0] r_hold_cnt;
  logic          r_y_out;
  logic          r_y_valid;
  logic          r_timeout;

  logic [2:0]    w_idx;
  logic [2:0]    w_win;
  logic          w_found;
  logic          w_start;
  logic          w_timeout_nxt;

  // First requester at or after the rotating pointer wins.
  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_RECOVER: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        // A release on the last allowed cycle wins over the timeout.
        if (!bus.req[r_sel]) begin
          w_state_nxt = S_RECOVER;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt   = S_RECOVER;
          w_timeout_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt      <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_y_out    <= 1'b0;
      r_y_valid  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
      r_y_valid <= (r_state == S_GRANT);
      r_y_out   <= (r_state == S_GRANT) & bus.d_in[r_sel];
      if (w_start) begin
        r_gnt      <= 8'h01 << w_win;
        r_sel      <= w_win;
        r_ptr      <= w_win + 3'd1;
        r_hold_cnt <= '0;
      end else if (w_state_nxt != S_GRANT) begin
        r_gnt <= '0;
      end
      if (r_state == S_GRANT && w_state_nxt == S_GRANT) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.busy    = (r_state == S_GRANT);
  assign bus.y_out   = r_y_out;
  assign bus.y_valid = r_y_valid;
  assign bus.timeout = r_timeout;

endmodule
